// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_rx_pkg;

  localparam int MAX_DATA_BITS = 9;

  // Holding-register contents; data is sized for the widest payload.
  typedef struct packed {
    logic [MAX_DATA_BITS-1:0] data;
    logic                     stop_ok;
    logic                     parity_err;
  } rx_frame_t;

  function automatic int frame_bits(input int data_bits, input int parity_en,
                                    input int stop_bits);
    return data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Wrap counter for received bits; tc pulses on the enable that reaches WRAP.
module rx_bit_counter #(
  parameter int WRAP = 9,
  parameter int CW   = $clog2(WRAP + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          tc
);

  // clear suppresses the terminal count so an aborted frame never completes.
  assign tc = enable && !clear && (count == CW'(WRAP - 1));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state, so every flop samples pre-edge values.
    if (!n_rst)       count <= '0;
    else if (clear)   count <= '0;
    else if (tc)      count <= '0;
    else if (enable)  count <= count + 1'b1;
  end

endmodule

// File: rtl/rx_frame_sr.sv
// UART receive frame register: shift in bits, decode on completion, hold with valid/ready.
module rx_frame_sr
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_EN, STOP_BITS),
  localparam int CW         = $clog2(FRAME_BITS + 1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 shift_strobe,
  input  logic                 serial_in,
  input  logic                 clear,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] packet_data,
  output logic                 stop_ok,
  output logic                 parity_err,
  output logic                 out_valid,
  output logic                 overrun,
  output logic [CW-1:0]        bit_count
);

  logic [FRAME_BITS-1:0] sr;
  logic                  tc;
  logic                  done_q;
  rx_frame_t             frame_d;
  rx_frame_t             hold_q;
  logic                  valid_q;
  logic                  overrun_q;
  logic                  unused_hold;

  rx_bit_counter #(.WRAP(FRAME_BITS), .CW(CW)) u_counter (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (clear),
    .enable (shift_strobe),
    .count  (bit_count),
    .tc     (tc)
  );

  // Idle line is all ones; new bits enter at the MSB so the first bit ends up at bit 0.
  always_ff @(posedge clk) begin
    if (!n_rst)            sr <= '1;
    else if (clear)        sr <= '1;
    else if (shift_strobe) sr <= {serial_in, sr[FRAME_BITS-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!n_rst) done_q <= 1'b0;
    else        done_q <= tc;
  end

  always_comb begin
    // NOTE: default every field first so no path through this block can infer a latch.
    frame_d                      = '0;
    frame_d.data[DATA_BITS-1:0]  = sr[DATA_BITS-1:0];
    frame_d.stop_ok              = &sr[FRAME_BITS-1 -: STOP_BITS];
    if (PARITY_EN != 0)
      frame_d.parity_err = (^sr[DATA_BITS:0]) ^ 1'(PARITY_ODD);
  end

  // A completion is accepted if the register is empty or being drained this cycle.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hold_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (done_q) begin
        if (!valid_q || out_ready) begin
          hold_q  <= frame_d;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
      if (clear) overrun_q <= 1'b0;
    end
  end

  assign packet_data = hold_q.data[DATA_BITS-1:0];
  assign stop_ok     = hold_q.stop_ok;
  assign parity_err  = hold_q.parity_err;
  assign out_valid   = valid_q;
  assign overrun     = overrun_q;
  assign unused_hold = ^hold_q.data;

endmodule

// File: tb/tb_rx_frame_sr.sv
// Bench for rx_frame_sr: default config (dut 0) and 7E2 config (dut 1) against a frame-level model.
module tb_rx_frame_sr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst [2];
  logic strobe[2];
  logic serial[2];
  logic clr   [2];
  logic rdy   [2];

  logic [7:0] pd_a;  logic [6:0] pd_b;
  logic stop_a, stop_b, perr_a, perr_b, val_a, val_b, ovr_a, ovr_b;
  logic [3:0] bc_a, bc_b;

  rx_frame_sr u_dut_a (
    .clk(clk), .n_rst(n_rst[0]), .shift_strobe(strobe[0]), .serial_in(serial[0]),
    .clear(clr[0]), .out_ready(rdy[0]), .packet_data(pd_a), .stop_ok(stop_a),
    .parity_err(perr_a), .out_valid(val_a), .overrun(ovr_a), .bit_count(bc_a)
  );

  rx_frame_sr #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .n_rst(n_rst[1]), .shift_strobe(strobe[1]), .serial_in(serial[1]),
    .clear(clr[1]), .out_ready(rdy[1]), .packet_data(pd_b), .stop_ok(stop_b),
    .parity_err(perr_b), .out_valid(val_b), .overrun(ovr_b), .bit_count(bc_b)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Frame layout of each instance.
  function automatic int db(int s); return (s == 0) ? 8 : 7; endfunction
  function automatic int pe(int s); return (s == 0) ? 0 : 1; endfunction
  function automatic int sb(int s); return (s == 0) ? 1 : 2; endfunction
  function automatic int fb(int s); return db(s) + pe(s) + sb(s); endfunction

  // Reference model: bits stored by position within the frame, fields computed on completion.
  int         m_cnt  [2];
  logic       m_bits [2][16];
  logic       m_pend [2];
  logic [8:0] p_data [2];
  logic       p_stop [2];
  logic       p_perr [2];
  logic       m_valid[2];
  logic [8:0] h_data [2];
  logic       h_stop [2];
  logic       h_perr [2];
  logic       m_ovr  [2];

  task automatic model_step(int s);
    logic new_pend;
    int   ones;
    new_pend = 1'b0;
    if (!n_rst[s]) begin
      m_cnt[s] = 0; m_pend[s] = 0; m_valid[s] = 0;
      h_data[s] = 0; h_stop[s] = 0; h_perr[s] = 0; m_ovr[s] = 0;
      return;
    end
    if (m_pend[s]) begin
      if (!m_valid[s] || rdy[s]) begin
        h_data[s] = p_data[s]; h_stop[s] = p_stop[s]; h_perr[s] = p_perr[s];
        m_valid[s] = 1'b1;
      end else begin
        m_ovr[s] = 1'b1;
      end
    end else if (m_valid[s] && rdy[s]) begin
      m_valid[s] = 1'b0;
    end
    if (clr[s]) begin
      m_cnt[s] = 0;
      m_ovr[s] = 1'b0;
    end else if (strobe[s]) begin
      m_bits[s][m_cnt[s]] = serial[s];
      m_cnt[s]++;
      if (m_cnt[s] == fb(s)) begin
        p_data[s] = '0;
        ones = 0;
        for (int i = 0; i < db(s); i++) begin
          p_data[s][i] = m_bits[s][i];
          ones += int'(m_bits[s][i]);
        end
        p_perr[s] = (pe(s) != 0) ? (((ones + int'(m_bits[s][db(s)])) % 2) != 0) : 1'b0;
        p_stop[s] = 1'b1;
        for (int i = db(s) + pe(s); i < fb(s); i++) p_stop[s] = p_stop[s] & m_bits[s][i];
        new_pend = 1'b1;
        m_cnt[s] = 0;
      end
    end
    m_pend[s] = new_pend;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(string tag, int s);
    if (s == 0) begin
      chk($sformatf("%s/a out_valid", tag),  32'(val_a),  32'(m_valid[0]));
      chk($sformatf("%s/a packet_data", tag), 32'(pd_a),  32'(h_data[0]));
      chk($sformatf("%s/a stop_ok", tag),    32'(stop_a), 32'(h_stop[0]));
      chk($sformatf("%s/a parity_err", tag), 32'(perr_a), 32'(h_perr[0]));
      chk($sformatf("%s/a overrun", tag),    32'(ovr_a),  32'(m_ovr[0]));
      chk($sformatf("%s/a bit_count", tag),  32'(bc_a),   32'(m_cnt[0]));
    end else begin
      chk($sformatf("%s/b out_valid", tag),  32'(val_b),  32'(m_valid[1]));
      chk($sformatf("%s/b packet_data", tag), 32'(pd_b),  32'(h_data[1]));
      chk($sformatf("%s/b stop_ok", tag),    32'(stop_b), 32'(h_stop[1]));
      chk($sformatf("%s/b parity_err", tag), 32'(perr_b), 32'(h_perr[1]));
      chk($sformatf("%s/b overrun", tag),    32'(ovr_b),  32'(m_ovr[1]));
      chk($sformatf("%s/b bit_count", tag),  32'(bc_b),   32'(m_cnt[1]));
    end
  endtask

  // One clock: inputs were set at the previous negedge, model follows the edge, outputs checked at negedge.
  task automatic tick(string tag);
    @(posedge clk);
    for (int s = 0; s < 2; s++) model_step(s);
    @(negedge clk);
    for (int s = 0; s < 2; s++) check_dut(tag, s);
  endtask

  task automatic send(int s, logic [15:0] bits, string tag);
    for (int i = 0; i < fb(s); i++) begin
      serial[s] = bits[i];
      strobe[s] = 1'b1;
      tick(tag);
    end
    strobe[s] = 1'b0;
    serial[s] = 1'b1;
  endtask

  task automatic drain(int s);
    rdy[s] = 1'b1;
    tick("drain");
    rdy[s] = 1'b0;
  endtask

  function automatic logic [15:0] frame_a(logic [7:0] d, logic stop);
    return {7'b0, stop, d};
  endfunction

  function automatic logic [15:0] frame_b(logic [6:0] d, logic par, logic s1, logic s2);
    return {6'b0, s2, s1, par, d};
  endfunction

  initial begin
    for (int s = 0; s < 2; s++) begin
      n_rst[s] = 1'b0; strobe[s] = 1'b0; serial[s] = 1'b1; clr[s] = 1'b0; rdy[s] = 1'b0;
      m_cnt[s] = 0; m_pend[s] = 0; m_valid[s] = 0; m_ovr[s] = 0;
      h_data[s] = 0; h_stop[s] = 0; h_perr[s] = 0;
      p_data[s] = 0; p_stop[s] = 0; p_perr[s] = 0;
    end
    @(negedge clk);

    // Reset state.
    tick("reset");
    chk("reset out_valid", 32'(val_a), 32'd0);
    chk("reset bit_count", 32'(bc_a), 32'd0);
    n_rst[0] = 1'b1; n_rst[1] = 1'b1;
    tick("post_reset");

    // Basic 8N1 frame 0x55.
    send(0, frame_a(8'h55, 1'b1), "basic");
    chk("basic not yet valid", 32'(val_a), 32'd0);
    tick("basic_done");
    chk("basic out_valid", 32'(val_a), 32'd1);
    chk("basic packet_data", 32'(pd_a), 32'h55);
    chk("basic stop_ok", 32'(stop_a), 32'd1);
    chk("basic parity_err", 32'(perr_a), 32'd0);
    chk("basic bit_count", 32'(bc_a), 32'd0);
    drain(0);

    // Framing error.
    send(0, frame_a(8'hA3, 1'b0), "framing");
    tick("framing_done");
    chk("framing packet_data", 32'(pd_a), 32'hA3);
    chk("framing stop_ok", 32'(stop_a), 32'd0);
    drain(0);

    // Parity on the 7E2 instance.
    send(1, frame_b(7'h41, 1'b0, 1'b1, 1'b1), "par_ok");
    tick("par_ok_done");
    chk("par_ok packet_data", 32'(pd_b), 32'h41);
    chk("par_ok parity_err", 32'(perr_b), 32'd0);
    chk("par_ok stop_ok", 32'(stop_b), 32'd1);
    drain(1);
    send(1, frame_b(7'h41, 1'b1, 1'b1, 1'b1), "par_bad");
    tick("par_bad_done");
    chk("par_bad parity_err", 32'(perr_b), 32'd1);
    drain(1);
    send(1, frame_b(7'h41, 1'b0, 1'b1, 1'b0), "stop2_bad");
    tick("stop2_bad_done");
    chk("stop2_bad stop_ok", 32'(stop_b), 32'd0);
    drain(1);

    // Overrun, clear, then completion concurrent with a transfer.
    send(0, frame_a(8'h11, 1'b1), "ovr1");
    send(0, frame_a(8'h22, 1'b1), "ovr2");
    tick("ovr2_done");
    chk("ovr packet_data held", 32'(pd_a), 32'h11);
    chk("ovr overrun", 32'(ovr_a), 32'd1);
    clr[0] = 1'b1;
    tick("ovr_clear");
    clr[0] = 1'b0;
    chk("clear overrun", 32'(ovr_a), 32'd0);
    chk("clear out_valid kept", 32'(val_a), 32'd1);
    send(0, frame_a(8'h33, 1'b1), "ovr3");
    rdy[0] = 1'b1;
    tick("ovr3_done");
    rdy[0] = 1'b0;
    chk("swap out_valid", 32'(val_a), 32'd1);
    chk("swap packet_data", 32'(pd_a), 32'h33);
    chk("swap overrun", 32'(ovr_a), 32'd0);
    drain(0);

    // Clear mid-frame with a simultaneous strobe.
    for (int i = 0; i < 4; i++) begin
      serial[0] = 1'b0; strobe[0] = 1'b1;
      tick("pre_clear");
    end
    chk("pre_clear bit_count", 32'(bc_a), 32'd4);
    clr[0] = 1'b1;
    tick("clear_strobe");
    clr[0] = 1'b0; strobe[0] = 1'b0;
    chk("clear_strobe bit_count", 32'(bc_a), 32'd0);
    send(0, frame_a(8'h7E, 1'b1), "resync");
    tick("resync_done");
    chk("resync packet_data", 32'(pd_a), 32'h7E);
    chk("resync stop_ok", 32'(stop_a), 32'd1);

    // Reset mid-frame with a held frame and overrun pending.
    send(0, frame_a(8'h5A, 1'b1), "pre_rst");
    tick("pre_rst_done");
    chk("pre_rst overrun", 32'(ovr_a), 32'd1);
    for (int i = 0; i < 3; i++) begin
      serial[0] = 1'b1; strobe[0] = 1'b1;
      tick("mid_rst");
    end
    n_rst[0] = 1'b0;
    tick("rst_edge");
    strobe[0] = 1'b0; n_rst[0] = 1'b1;
    chk("rst out_valid", 32'(val_a), 32'd0);
    chk("rst packet_data", 32'(pd_a), 32'd0);
    chk("rst overrun", 32'(ovr_a), 32'd0);
    chk("rst bit_count", 32'(bc_a), 32'd0);
    chk("rst stop_ok", 32'(stop_a), 32'd0);

    // Random traffic on both instances.
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < 2; s++) begin
        strobe[s] = 1'($urandom_range(0, 3) != 0);
        serial[s] = 1'($urandom);
        rdy[s]    = 1'($urandom_range(0, 5) == 0);
        clr[s]    = 1'($urandom_range(0, 40) == 0);
        n_rst[s]  = 1'($urandom_range(0, 150) != 0);
      end
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
